// File: rtl/img_pkg.sv
// Shared types and constants for the streaming grayscale/Sobel pipeline.
package img_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY  = 2'd0,
    MODE_SOBEL = 2'd1,
    MODE_BIN   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_e;

  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

  // The reserved encoding 3 behaves exactly like the Sobel magnitude mode.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd0:    return MODE_GRAY;
      2'd2:    return MODE_BIN;
      default: return MODE_SOBEL;
    endcase
  endfunction

endpackage

// File: rtl/sobel_window_kernel.sv
// Combinational 3x3 Sobel: window index r*3+c (row 0 oldest, col 2 newest),
// returns |Gx|+|Gy| saturated to PIX_W bits.
module sobel_window_kernel
  import img_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [8:0][PIX_W-1:0] win,
  output logic [PIX_W-1:0]      mag
);

  localparam int GW = PIX_W + 3;

  logic signed [GW-1:0] p [9];
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic        [GW-1:0] ax;
  logic        [GW-1:0] ay;
  logic        [GW:0]   sum;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      p[i] = $signed({3'b000, win[i]});
    end
    gx  = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
    gy  = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    sum = {1'b0, ax} + {1'b0, ay};
    mag = (|sum[GW:PIX_W]) ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
  end

endmodule

// File: rtl/stream_edge_pipeline.sv
// Streaming RGB->gray->Sobel pipeline using two line buffers, one result per pixel.
// Optional macro EDGE_STATS_EN adds the per-frame edge_count output.
module stream_edge_pipeline
  import img_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [3*PIX_W-1:0] s_data,
  input  logic               s_sof,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   thresh,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIX_W-1:0]   m_data,
  output logic               m_last,
  output logic               frame_done,
  output logic               sof_err
`ifdef EDGE_STATS_EN
  , output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int YW = 8 + PIX_W + 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e                 state, state_next;
  mode_e                  mode_q;
  logic [PIX_W-1:0]       thresh_q;
  logic [CW-1:0]          in_col, out_col;
  logic [RW-1:0]          in_row, out_row;
  logic [PIX_W-1:0]       lb1 [IMG_W];
  logic [PIX_W-1:0]       lb2 [IMG_W];
  logic [8:0][PIX_W-1:0]  win_q, win_next;
  logic [YW-1:0]          y_sum;
  logic [PIX_W-1:0]       y_pix, sobel_mag, load_data, load_mag;
  logic                   accept, take, start, out_free, out_hs;
  logic                   load_run, load_flush, load, border;

  assign y_sum = YW'(LUMA_R) * YW'(s_data[3*PIX_W-1 -: PIX_W])
               + YW'(LUMA_G) * YW'(s_data[2*PIX_W-1 -: PIX_W])
               + YW'(LUMA_B) * YW'(s_data[PIX_W-1:0]);
  assign y_pix = PIX_W'(y_sum >> LUMA_SHIFT);

  assign accept   = s_valid && s_ready;
  assign start    = (state == IDLE) && accept && s_sof;
  assign take     = accept && ((state != IDLE) || s_sof);
  assign out_free = !m_valid || m_ready;
  assign out_hs   = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (start) state_next = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        // Index IMG_W (row 1, col 0) is the last beat before outputs begin.
        if (accept && in_row == RW'(1) && in_col == '0) state_next = RUN;
      end
      RUN: begin
        s_ready = out_free;
        if (accept && in_row == ROW_LAST && in_col == COL_LAST) state_next = FLUSH;
      end
      FLUSH: begin
        if (out_hs && m_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_run   = (state == RUN) && accept;
  assign load_flush = (state == FLUSH) && out_free && !(m_valid && m_last);
  assign load       = load_run || load_flush;
  assign border     = (out_row == '0) || (out_row == ROW_LAST)
                   || (out_col == '0) || (out_col == COL_LAST);

  // Window after shifting in the column {pixel j-2W, pixel j-W, pixel j}.
  always_comb begin
    win_next = win_q;
    for (int r = 0; r < 3; r++) begin
      win_next[r*3]   = win_q[r*3+1];
      win_next[r*3+1] = win_q[r*3+2];
    end
    win_next[2] = lb2[in_col];
    win_next[5] = lb1[in_col];
    win_next[8] = y_pix;
  end

  sobel_window_kernel #(.PIX_W(PIX_W)) u_kernel (
    .win (win_next),
    .mag (sobel_mag)
  );

  // Flush outputs are all border pixels; only gray mode needs data, read from the line buffers.
  always_comb begin
    load_mag  = '0;
    load_data = '0;
    if (state == FLUSH) begin
      if (mode_q == MODE_GRAY)
        load_data = (out_row == ROW_LAST) ? lb1[out_col] : lb2[out_col];
    end else begin
      if (!border) load_mag = sobel_mag;
      case (mode_q)
        MODE_GRAY: load_data = win_next[4];
        MODE_BIN:  load_data = (!border && load_mag >= thresh_q) ? {PIX_W{1'b1}} : '0;
        default:   load_data = load_mag;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_GRAY;
      thresh_q   <= '0;
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      win_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= (state == FLUSH) && out_hs && m_last;
      sof_err    <= accept && s_sof && (state == FILL || state == RUN);
      if (start) begin
        mode_q   <= decode_mode(mode);
        thresh_q <= thresh;
        out_col  <= '0;
        out_row  <= '0;
      end
      if (take) begin
        win_q  <= win_next;
        in_col <= (in_col == COL_LAST) ? '0 : in_col + 1'b1;
        if (in_col == COL_LAST) in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
      end
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_last  <= (out_row == ROW_LAST) && (out_col == COL_LAST);
        out_col <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
        if (out_col == COL_LAST) out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
      end else if (out_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

  // NOTE: the line buffers are cleared by reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
    end else if (take) begin
      lb2[in_col] <= lb1[in_col];
      lb1[in_col] <= y_pix;
    end
  end

`ifdef EDGE_STATS_EN
  logic hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      edge_count <= '0;
    end else begin
      if (load) hit_q <= (load_mag >= thresh_q);
      if (start)                edge_count <= '0;
      else if (out_hs && hit_q) edge_count <= edge_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_edge_pipeline.sv
// Randomized bench for stream_edge_pipeline (8x8 frames) against a 2-D image reference model.
module tb_stream_edge_pipeline;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  thresh = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_last;
  logic        frame_done;
  logic        sof_err;

  always #5 clk = ~clk;

  stream_edge_pipeline #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .mode       (mode),
    .thresh     (thresh),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] d;
    logic        sof;
  } beat_t;

  logic [23:0] img [N];
  beat_t       beats [$];
  logic [7:0]  got_d [$];
  logic        got_l [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int luma(int p);
    int r, g, b;
    r = int'(img[p][23:16]);
    g = int'(img[p][15:8]);
    b = int'(img[p][7:0]);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Reference: output k is the pixel at row k/W, column k%W of the whole frame.
  function automatic logic [7:0] model(int k, logic [1:0] md, logic [7:0] th);
    int r, c, gx, gy, v, mag;
    r = k / W;
    c = k % W;
    if (md == 2'd0) return 8'(luma(k));
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    gx = 0;
    gy = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        v  = luma((r + dr) * W + c + dc);
        gx += KX[(dr + 1) * 3 + dc + 1] * v;
        gy += KY[(dr + 1) * 3 + dc + 1] * v;
      end
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (md == 2'd2) return (mag >= int'(th)) ? 8'd255 : 8'd0;
    return 8'(mag);
  endfunction

  task automatic run_frame(input string name, input logic [1:0] md, input logic [7:0] th,
                           input int vprob, input int rprob, input int junk,
                           input int extra_sof, input int abort_at);
    int bi = 0, cyc = 0, last_cyc = -1, serr = 0;
    bit done = 0, stalled = 0, aborted = 0;
    logic [7:0] hold_d = '0;
    logic       hold_l = 1'b0;
    beats.delete();
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < junk; i++) beats.push_back('{24'($urandom), 1'b0});
    for (int i = 0; i < N; i++) beats.push_back('{img[i], (i == 0 || i == extra_sof)});
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && got_d.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({name, "_rst_valid"}, m_valid, 0);
        check({name, "_rst_data"}, m_data, 0);
        check({name, "_rst_last"}, m_last, 0);
        check({name, "_rst_ready"}, s_ready, 1);
        aborted = 1;
        break;
      end
      if (bi < beats.size()) begin
        s_valid = ($urandom_range(99) < vprob);
        s_data  = beats[bi].d;
        s_sof   = beats[bi].sof;
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
      end
      // After the start beat the configuration inputs wander; the frame must keep its latched copy.
      if (bi > junk) begin
        mode   = 2'($urandom);
        thresh = 8'($urandom);
      end else begin
        mode   = md;
        thresh = th;
      end
      m_ready = ($urandom_range(99) < rprob);
      #1;
      if (stalled) begin
        check({name, "_stall_valid"}, m_valid, 1);
        check({name, "_stall_data"}, m_data, hold_d);
        check({name, "_stall_last"}, m_last, hold_l);
      end
      if (sof_err) serr++;
      if (frame_done) begin
        check({name, "_fd_timing"}, cyc, last_cyc + 1);
        done = 1;
      end
      stalled = m_valid && !m_ready;
      hold_d  = m_data;
      hold_l  = m_last;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        if (m_last) last_cyc = cyc;
      end
      if (s_valid && s_ready) bi++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        #1;
        check({name, "_rst_fd"}, frame_done, 0);
        check({name, "_rst_mvalid"}, m_valid, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    check({name, "_fd_seen"}, done, 1);
    check({name, "_count"}, got_d.size(), N);
    check({name, "_sof_err"}, serr, (extra_sof > 0) ? 1 : 0);
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      check($sformatf("%s_d%0d", name, i), got_d[i], model(i, md, th));
      check($sformatf("%s_l%0d", name, i), got_l[i], (i == N - 1) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check({name, "_fd_pulse"}, frame_done, 0);
    check({name, "_idle_valid"}, m_valid, 0);
  endtask

  task automatic random_img();
    for (int i = 0; i < N; i++) img[i] = 24'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_last", m_last, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_sof_err", sof_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) img[i] = {8'd200, 8'd100, 8'd50};
    run_frame("gray_const", 2'd0, 8'd0, 100, 100, 0, 0, 0);
    if (got_d.size() > 0) check("gray_const_124", got_d[0], 124);

    for (int i = 0; i < N; i++) img[i] = (i % W >= 4) ? 24'hFFFFFF : 24'h000000;
    run_frame("step_sobel", 2'd1, 8'd0, 100, 100, 0, 0, 0);
    if (got_d.size() == N) begin
      check("step_col3", got_d[3 * W + 3], 255);
      check("step_col4", got_d[3 * W + 4], 255);
      check("step_col2", got_d[3 * W + 2], 0);
    end
    run_frame("step_bin255", 2'd2, 8'd255, 100, 100, 0, 0, 0);
    run_frame("step_bin0", 2'd2, 8'd0, 100, 100, 0, 0, 0);

    random_img();
    run_frame("rand_sobel_nostall", 2'd1, 8'd0, 100, 100, 0, 0, 0);
    run_frame("rand_sobel_stall", 2'd1, 8'd0, 60, 50, 0, 0, 0);
    run_frame("rand_gray_stall", 2'd0, 8'd0, 70, 50, 0, 0, 0);

    random_img();
    run_frame("rand_bin_stall", 2'd2, 8'($urandom_range(40, 200)), 70, 50, 0, 0, 0);
    run_frame("rand_mode3", 2'd3, 8'd0, 80, 60, 0, 0, 0);

    random_img();
    run_frame("junk_sof20", 2'd1, 8'd0, 70, 50, 5, 20, 0);

    random_img();
    run_frame("abort30", 2'd0, 8'd0, 80, 50, 0, 0, 30);
    random_img();
    run_frame("after_abort", 2'd1, 8'd0, 80, 50, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
